// File: rtl/basic_axi4_lite_master.sv
// AXI4-Lite initiator: turns single user read/write commands into complete AXI4-Lite
// transactions, one outstanding at a time, with a one-cycle result pulse.
module basic_axi4_lite_master #(
  parameter  int p_ADDRESS_WIDTH = 2,
  parameter  int p_DATA_WIDTH    = 8,
  localparam int lp_STROBE_WIDTH = (p_DATA_WIDTH / 8 > 1) ? p_DATA_WIDTH / 8 : 1
) (
  input  logic                       i_ACLK,
  input  logic                       i_ARESET,
  input  logic                       i_CMD_VALID,
  output logic                       o_CMD_READY,
  input  logic                       i_CMD_WRITE,
  input  logic [p_ADDRESS_WIDTH-1:0] i_CMD_ADDR,
  input  logic [p_DATA_WIDTH-1:0]    i_CMD_WDATA,
  output logic                       o_RSP_VALID,
  output logic [p_DATA_WIDTH-1:0]    o_RSP_RDATA,
  output logic [1:0]                 o_RSP_RESP,
  output logic [p_ADDRESS_WIDTH-1:0] o_M_AWADDR,
  output logic                       o_M_AWVALID,
  input  logic                       i_S_AWREADY,
  output logic [2:0]                 o_M_AWPROT,
  output logic [p_DATA_WIDTH-1:0]    o_M_WDATA,
  output logic                       o_M_WVALID,
  input  logic                       i_S_WREADY,
  output logic [lp_STROBE_WIDTH-1:0] o_M_WSTRB,
  input  logic [1:0]                 i_S_BRESP,
  input  logic                       i_S_BVALID,
  output logic                       o_M_BREADY,
  output logic [p_ADDRESS_WIDTH-1:0] o_M_ARADDR,
  output logic                       o_M_ARVALID,
  input  logic                       i_S_ARREADY,
  output logic [2:0]                 o_M_ARPROT,
  input  logic [p_DATA_WIDTH-1:0]    i_S_RDATA,
  input  logic [1:0]                 i_S_RRESP,
  input  logic                       i_S_RVALID,
  output logic                       o_M_RREADY
);

  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t                     state_q, state_d;
  logic [p_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [p_DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                       awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                       aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                       bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [1:0]                 rsp_resp_q, rsp_resp_d;
  logic [p_DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;

  always_ff @(posedge i_ACLK or posedge i_ARESET) begin
    if (i_ARESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_resp_q  <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = 1'b0;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: if (i_CMD_VALID) begin
        addr_d  = i_CMD_ADDR;
        wdata_d = i_CMD_WDATA;
        if (i_CMD_WRITE) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_ADDR_DATA;
        end else begin
          arvalid_d = 1'b1;
          state_d   = RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        // AW and W retire independently; the later of the two opens the response phase
        if (awvalid_q && i_S_AWREADY) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && i_S_WREADY) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: if (i_S_BVALID && bready_q) begin
        rsp_resp_d  = i_S_BRESP;
        bready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      RD_ADDR: if (arvalid_q && i_S_ARREADY) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RD_DATA;
      end
      RD_DATA: if (i_S_RVALID && rready_q) begin
        rsp_rdata_d = i_S_RDATA;
        rsp_resp_d  = i_S_RRESP;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_CMD_READY = (state_q == IDLE);
  assign o_RSP_VALID = rsp_valid_q;
  assign o_RSP_RDATA = rsp_rdata_q;
  assign o_RSP_RESP  = rsp_resp_q;
  assign o_M_AWADDR  = addr_q;
  assign o_M_ARADDR  = addr_q;
  assign o_M_WDATA   = wdata_q;
  assign o_M_AWVALID = awvalid_q;
  assign o_M_WVALID  = wvalid_q;
  assign o_M_BREADY  = bready_q;
  assign o_M_ARVALID = arvalid_q;
  assign o_M_RREADY  = rready_q;
  assign o_M_AWPROT  = 3'b000;
  assign o_M_ARPROT  = 3'b000;
  assign o_M_WSTRB   = '1;

endmodule

// File: tb/tb_basic_axi4_lite_master.sv
// Scoreboard bench for basic_axi4_lite_master: a delay-programmable memory slave,
// an in-order reference model of expected results, and a decoupled response monitor.
module tb_basic_axi4_lite_master;
  localparam int AW = 2;
  localparam int DW = 8;

  logic          i_ACLK = 1'b0;
  logic          i_ARESET;
  logic          i_CMD_VALID, o_CMD_READY, i_CMD_WRITE;
  logic [AW-1:0] i_CMD_ADDR;
  logic [DW-1:0] i_CMD_WDATA;
  logic          o_RSP_VALID;
  logic [DW-1:0] o_RSP_RDATA;
  logic [1:0]    o_RSP_RESP;
  logic [AW-1:0] o_M_AWADDR, o_M_ARADDR;
  logic          o_M_AWVALID, i_S_AWREADY, o_M_WVALID, i_S_WREADY;
  logic [2:0]    o_M_AWPROT, o_M_ARPROT;
  logic [DW-1:0] o_M_WDATA, i_S_RDATA;
  logic [0:0]    o_M_WSTRB;
  logic [1:0]    i_S_BRESP, i_S_RRESP;
  logic          i_S_BVALID, o_M_BREADY, o_M_ARVALID, i_S_ARREADY, i_S_RVALID, o_M_RREADY;

  basic_axi4_lite_master #(.p_ADDRESS_WIDTH(AW), .p_DATA_WIDTH(DW)) dut (
    .i_ACLK(i_ACLK), .i_ARESET(i_ARESET),
    .i_CMD_VALID(i_CMD_VALID), .o_CMD_READY(o_CMD_READY), .i_CMD_WRITE(i_CMD_WRITE),
    .i_CMD_ADDR(i_CMD_ADDR), .i_CMD_WDATA(i_CMD_WDATA),
    .o_RSP_VALID(o_RSP_VALID), .o_RSP_RDATA(o_RSP_RDATA), .o_RSP_RESP(o_RSP_RESP),
    .o_M_AWADDR(o_M_AWADDR), .o_M_AWVALID(o_M_AWVALID), .i_S_AWREADY(i_S_AWREADY),
    .o_M_AWPROT(o_M_AWPROT), .o_M_WDATA(o_M_WDATA), .o_M_WVALID(o_M_WVALID),
    .i_S_WREADY(i_S_WREADY), .o_M_WSTRB(o_M_WSTRB), .i_S_BRESP(i_S_BRESP),
    .i_S_BVALID(i_S_BVALID), .o_M_BREADY(o_M_BREADY), .o_M_ARADDR(o_M_ARADDR),
    .o_M_ARVALID(o_M_ARVALID), .i_S_ARREADY(i_S_ARREADY), .o_M_ARPROT(o_M_ARPROT),
    .i_S_RDATA(i_S_RDATA), .i_S_RRESP(i_S_RRESP), .i_S_RVALID(i_S_RVALID),
    .o_M_RREADY(o_M_RREADY)
  );

  always #5 i_ACLK = ~i_ACLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: memory image plus "last read data" register seen by the user
  typedef struct { logic [1:0] resp; logic [DW-1:0] rdata; } exp_t;
  exp_t          exp_q[$];
  logic [1:0]    slv_resp_q[$];
  logic [DW-1:0] ref_mem [4];
  logic [DW-1:0] smem [4];
  logic [DW-1:0] last_rd;
  int            acc_cyc, pulse_cyc, br_rise, npulse;
  int            pulse_q[$];
  int            aw_hi, w_hi, ar_hi, r_hi;

  // Slave knobs: cycles of VALID before READY, and cycles from request to B/R VALID
  int k_aw, k_w, k_ar, k_b, k_r;
  bit rnd_mode, slv_clr;
  int aw_dly, w_dly, ar_dly, aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;

  function automatic int pick(input int k);
    return rnd_mode ? int'($urandom_range(0, 3)) : k;
  endfunction

  task automatic set_slave(input int a, input int w, input int ar, input int b, input int r, input bit rnd);
    k_aw = a; k_w = w; k_ar = ar; k_b = b; k_r = r; rnd_mode = rnd;
    aw_dly = pick(a); w_dly = pick(w); ar_dly = pick(ar);
  endtask

  initial forever @(posedge i_ACLK) cyc++;

  // Memory slave
  initial begin : slave
    bit aw_got, w_got, b_arm, r_arm, aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    logic [1:0] rs;
    aw_got = 0; w_got = 0; b_arm = 0; r_arm = 0;
    forever begin
      @(negedge i_ACLK);
      if (slv_clr || i_ARESET) begin
        aw_got = 0; w_got = 0; b_arm = 0; r_arm = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        i_S_AWREADY = 0; i_S_WREADY = 0; i_S_ARREADY = 0; i_S_BVALID = 0; i_S_RVALID = 0;
        slv_clr = 0;
        continue;
      end
      aw_hs = o_M_AWVALID && i_S_AWREADY;
      w_hs  = o_M_WVALID && i_S_WREADY;
      ar_hs = o_M_ARVALID && i_S_ARREADY;
      b_hs  = i_S_BVALID && o_M_BREADY;
      r_hs  = i_S_RVALID && o_M_RREADY;
      if (aw_hs) begin wa = o_M_AWADDR; aw_got = 1; aw_cnt = 0; aw_dly = pick(k_aw); end
      else if (o_M_AWVALID) aw_cnt++;
      if (w_hs) begin wd = o_M_WDATA; w_got = 1; w_cnt = 0; w_dly = pick(k_w); end
      else if (o_M_WVALID) w_cnt++;
      if (ar_hs) begin ra = o_M_ARADDR; r_arm = 1; r_cnt = pick(k_r); ar_cnt = 0; ar_dly = pick(k_ar); end
      else if (o_M_ARVALID) ar_cnt++;
      if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_arm = 1; b_cnt = pick(k_b); end
      @(posedge i_ACLK); #1;
      if (slv_clr || i_ARESET) continue;
      if (b_hs) i_S_BVALID = 0;
      if (r_hs) i_S_RVALID = 0;
      if (b_arm) begin
        if (b_cnt == 0) begin
          rs = (slv_resp_q.size() != 0) ? slv_resp_q.pop_front() : 2'b00;
          if (rs == 2'b00) smem[wa] = wd;
          i_S_BRESP = rs; i_S_BVALID = 1; b_arm = 0;
        end else b_cnt--;
      end
      if (r_arm) begin
        if (r_cnt == 0) begin
          rs = (slv_resp_q.size() != 0) ? slv_resp_q.pop_front() : 2'b00;
          i_S_RDATA = smem[ra]; i_S_RRESP = rs; i_S_RVALID = 1; r_arm = 0;
        end else r_cnt--;
      end
      i_S_AWREADY = o_M_AWVALID && (aw_cnt >= aw_dly);
      i_S_WREADY  = o_M_WVALID && (w_cnt >= w_dly);
      i_S_ARREADY = o_M_ARVALID && (ar_cnt >= ar_dly);
    end
  end

  // Response monitor and channel-stability checks
  initial begin : monitor
    exp_t e;
    bit p_rst, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rr, p_rv, p_br, p_bv;
    logic [AW-1:0] p_awa, p_ara;
    logic [DW-1:0] p_wd;
    p_rst = 1;
    forever begin
      @(negedge i_ACLK);
      if (!i_ARESET) begin
        if (o_M_AWVALID) aw_hi++;
        if (o_M_WVALID) w_hi++;
        if (o_M_ARVALID) ar_hi++;
        if (o_M_RREADY) r_hi++;
        if (o_M_BREADY && !p_br) br_rise = cyc;
        if (o_RSP_VALID) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
          else begin
            e = exp_q.pop_front();
            chk("rsp_resp", 32'(o_RSP_RESP), 32'(e.resp));
            chk("rsp_rdata", 32'(o_RSP_RDATA), 32'(e.rdata));
            chk("rsp_cmd_ready", 32'(o_CMD_READY), 32'd1);
            chk("wstrb", 32'(o_M_WSTRB), 32'd1);
            chk("prot", 32'({o_M_AWPROT, o_M_ARPROT}), 32'd0);
            pulse_cyc = cyc; pulse_q.push_back(cyc); npulse++;
          end
        end
        if (!p_rst) begin
          if (p_awv && !p_awr) chk("aw_hold", 32'({o_M_AWVALID, o_M_AWADDR}), 32'({1'b1, p_awa}));
          if (p_wv && !p_wr)   chk("w_hold", 32'({o_M_WVALID, o_M_WDATA}), 32'({1'b1, p_wd}));
          if (p_arv && !p_arr) chk("ar_hold", 32'({o_M_ARVALID, o_M_ARADDR}), 32'({1'b1, p_ara}));
          if (p_rr && !p_rv)   chk("rready_hold", 32'(o_M_RREADY), 32'd1);
          if (p_br && !p_bv)   chk("bready_hold", 32'(o_M_BREADY), 32'd1);
        end
      end
      p_rst = i_ARESET;
      p_awv = o_M_AWVALID; p_awr = i_S_AWREADY; p_awa = o_M_AWADDR;
      p_wv = o_M_WVALID; p_wr = i_S_WREADY; p_wd = o_M_WDATA;
      p_arv = o_M_ARVALID; p_arr = i_S_ARREADY; p_ara = o_M_ARADDR;
      p_rr = o_M_RREADY; p_rv = i_S_RVALID; p_br = o_M_BREADY; p_bv = i_S_BVALID;
    end
  end

  task automatic idle_junk();
    i_CMD_VALID = 0;
    i_CMD_WRITE = 1'($urandom);
    i_CMD_ADDR  = AW'($urandom);
    i_CMD_WDATA = DW'($urandom);
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] rs);
    exp_t e;
    bit got;
    int n;
    if (wr) begin
      if (rs == 2'b00) ref_mem[a] = d;
    end else last_rd = ref_mem[a];
    e.resp = rs; e.rdata = last_rd;
    exp_q.push_back(e);
    slv_resp_q.push_back(rs);
    i_CMD_VALID = 1; i_CMD_WRITE = wr; i_CMD_ADDR = a; i_CMD_WDATA = d;
    got = 0; n = 0;
    while (!got && n < 300) begin
      @(negedge i_ACLK);
      if (o_CMD_READY) begin got = 1; acc_cyc = cyc; end
      @(posedge i_ACLK); #1;
      n++;
    end
    idle_junk();
    chk("cmd_accepted", 32'(got), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(posedge i_ACLK); #1; n++; end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) begin @(posedge i_ACLK); #1; end
  endtask

  initial begin
    int a1, a2, np;
    logic [1:0] rs;
    i_ARESET = 1; slv_clr = 0; idle_junk();
    i_S_AWREADY = 0; i_S_WREADY = 0; i_S_ARREADY = 0; i_S_BVALID = 0; i_S_RVALID = 0;
    i_S_BRESP = 0; i_S_RRESP = 0; i_S_RDATA = 0;
    for (int i = 0; i < 4; i++) begin smem[i] = DW'($urandom); ref_mem[i] = smem[i]; end
    last_rd = 0; npulse = 0; br_rise = 0; pulse_cyc = 0; acc_cyc = 0;
    set_slave(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge i_ACLK);
    chk("rst_awvalid", 32'(o_M_AWVALID), 32'd0);
    chk("rst_wvalid", 32'(o_M_WVALID), 32'd0);
    chk("rst_bready", 32'(o_M_BREADY), 32'd0);
    chk("rst_arvalid", 32'(o_M_ARVALID), 32'd0);
    chk("rst_rready", 32'(o_M_RREADY), 32'd0);
    chk("rst_rsp_valid", 32'(o_RSP_VALID), 32'd0);
    chk("rst_rsp_resp", 32'(o_RSP_RESP), 32'd0);
    chk("rst_rsp_rdata", 32'(o_RSP_RDATA), 32'd0);
    chk("rst_addr", 32'({o_M_AWADDR, o_M_ARADDR}), 32'd0);
    chk("rst_wdata", 32'(o_M_WDATA), 32'd0);
    chk("rst_cmd_ready", 32'(o_CMD_READY), 32'd1);
    @(posedge i_ACLK); #1; i_ARESET = 0;
    @(posedge i_ACLK); #1;

    // zero-wait write
    aw_hi = 0; w_hi = 0;
    issue(1, 2'd2, 8'h5A, 2'b00); drain();
    chk("wr_awvalid_cycles", 32'(aw_hi), 32'd1);
    chk("wr_wvalid_cycles", 32'(w_hi), 32'd1);
    chk("wr_latency", 32'(pulse_cyc - acc_cyc), 32'd3);

    // read with four wait cycles before RVALID
    issue(1, 2'd1, 8'h09, 2'b00); drain();
    set_slave(0, 0, 0, 0, 4, 0);
    ar_hi = 0; r_hi = 0;
    issue(0, 2'd1, 8'h00, 2'b00); drain();
    chk("rd_arvalid_cycles", 32'(ar_hi), 32'd1);
    chk("rd_rready_cycles", 32'(r_hi), 32'd5);
    chk("rd_latency", 32'(pulse_cyc - acc_cyc), 32'd7);
    chk("rd_data_hold", 32'(o_RSP_RDATA), 32'h09);

    // skewed write: W accepted four cycles after AW
    set_slave(0, 4, 0, 0, 0, 0);
    aw_hi = 0; w_hi = 0;
    issue(1, 2'd3, 8'hC3, 2'b00); drain();
    chk("skew_awvalid_cycles", 32'(aw_hi), 32'd1);
    chk("skew_wvalid_cycles", 32'(w_hi), 32'd5);
    chk("skew_bready_rise", 32'(br_rise - acc_cyc), 32'd6);

    // error responses pass through
    set_slave(0, 0, 0, 1, 1, 0);
    np = npulse;
    issue(1, 2'd0, 8'hEE, 2'b10); drain();
    chk("slverr_resp", 32'(o_RSP_RESP), 32'd2);
    issue(0, 2'd0, 8'h00, 2'b11); drain();
    chk("decerr_resp", 32'(o_RSP_RESP), 32'd3);
    chk("err_pulses", 32'(npulse - np), 32'd2);

    // reset while ARVALID is stalled
    set_slave(0, 0, 100, 0, 0, 0);
    issue(0, 2'd3, 8'h00, 2'b00);
    @(posedge i_ACLK); #3;
    chk("pre_rst_arvalid", 32'(o_M_ARVALID), 32'd1);
    np = npulse;
    i_ARESET = 1; slv_clr = 1;
    exp_q.delete(); slv_resp_q.delete(); last_rd = 0;
    #1;
    chk("async_rst_arvalid", 32'(o_M_ARVALID), 32'd0);
    chk("async_rst_cmd_ready", 32'(o_CMD_READY), 32'd1);
    chk("async_rst_rdata", 32'(o_RSP_RDATA), 32'd0);
    repeat (2) @(posedge i_ACLK);
    #3; i_ARESET = 0;
    @(posedge i_ACLK); #1;
    set_slave(0, 0, 0, 0, 0, 0);
    chk("rst_no_pulse", 32'(npulse - np), 32'd0);
    issue(0, 2'd3, 8'h00, 2'b00); drain();
    chk("post_rst_pulse", 32'(npulse - np), 32'd1);

    // back-to-back write then read
    pulse_q.delete();
    issue(1, 2'd1, 8'hA7, 2'b00); a1 = acc_cyc;
    issue(0, 2'd1, 8'h00, 2'b00); a2 = acc_cyc;
    drain();
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd3);
    chk("b2b_pulses", 32'(pulse_q.size()), 32'd2);
    if (pulse_q.size() == 2) chk("b2b_pulse_gap", 32'(pulse_q[1] - pulse_q[0]), 32'd3);

    // randomized traffic with random slave timing
    set_slave(0, 0, 0, 0, 0, 1);
    for (int t = 0; t < 120; t++) begin
      case ($urandom_range(0, 9))
        7, 8:    rs = 2'b10;
        9:       rs = 2'b11;
        default: rs = 2'b00;
      endcase
      issue(1'($urandom), AW'($urandom), DW'($urandom), rs);
      repeat ($urandom_range(0, 2)) begin @(posedge i_ACLK); #1; end
    end
    drain();
    for (int i = 0; i < 4; i++) begin
      set_slave(0, 0, 0, 0, 0, 0);
      issue(0, AW'(i), 8'h00, 2'b00);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
